clk_enable_gen: RTL

//  Multi-channel programmable clock-enable generator; replaces fixed-rate toggling dividers.

---
 rtl/clk_en_pkg.sv | 13 +
 rtl/clk_en_channel.sv | 82 ++++++++
 rtl/clk_enable_gen.sv | 71 +++++++
 3 files changed

// File: rtl/clk_en_pkg.sv
// Shared constants and helpers for the programmable clock-enable generator.
// Imported by the channel sub-module and the top level.
package clk_en_pkg;

  localparam int MIN_DIV          = 2;
  localparam int DEF_DIV_100M_5HZ = 10_000_000;

  // Width of a channel index; a single channel still needs a 1-bit select port.
  function automatic int CH_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_channel.sv
// One clock-enable channel: period counter, active/staged divisor, tick and toggle.
// A staged divisor is adopted only at a period boundary, or at once while the channel is idle.
module clk_en_channel
  import clk_en_pkg::*;
#(
  parameter int CNT_W   = 25,
  parameter int DEF_DIV = DEF_DIV_100M_5HZ
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wr_val,
  output logic             o_tick,
  output logic             o_slow_clk
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             slow_q, slow_d;
  logic             terminal;

  assign terminal = (cnt_q >= (div_q - CNT_W'(1)));

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    tick_d   = 1'b0;
    slow_d   = slow_q;
    if (i_enable) begin
      if (terminal) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        slow_d = ~slow_q;
        if (pend_q) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
      if (pend_q) begin
        div_d  = shadow_q;
        pend_d = 1'b0;
      end
    end
    // A fresh write overrides an apply happening on the same edge, so it stays staged.
    if (i_wr) begin
      shadow_d = i_wr_val;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      div_q    <= CNT_W'(DEF_DIV);
      shadow_q <= '0;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      slow_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      slow_q   <= slow_d;
    end
  end

  assign o_tick     = tick_q;
  assign o_slow_clk = slow_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator.
// Validates divisor writes, routes accepted ones to a channel and reports ack/err one cycle later.
module clk_enable_gen
  import clk_en_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 25,
  parameter int DEF_DIV = DEF_DIV_100M_5HZ
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_CH-1:0]             i_enable,
  input  logic                          i_div_wr,
  input  logic [CH_IDX_W(NUM_CH)-1:0]   i_div_ch,
  input  logic [CNT_W-1:0]              i_div_val,
  output logic                          o_div_ack,
  output logic                          o_div_err,
  output logic [NUM_CH-1:0]             o_tick,
  output logic [NUM_CH-1:0]             o_slow_clk
);

  localparam int CH_W = CH_IDX_W(NUM_CH);

  logic              ch_ok;
  logic              val_ok;
  logic              wr_valid;
  logic [NUM_CH-1:0] ch_wr;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  // Widen the index by one bit so a non-power-of-two channel count can be range-checked.
  assign ch_ok    = ({1'b0, i_div_ch} < (CH_W+1)'(NUM_CH));
  assign val_ok   = (i_div_val >= CNT_W'(MIN_DIV));
  assign wr_valid = i_div_wr && ch_ok && val_ok;

  always_comb begin
    ack_d = wr_valid;
    err_d = i_div_wr && !wr_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign o_div_ack = ack_q;
  assign o_div_err = err_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_wr[c] = wr_valid && (i_div_ch == CH_W'(c));

    clk_en_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_enable   (i_enable[c]),
      .i_wr       (ch_wr[c]),
      .i_wr_val   (i_div_val),
      .o_tick     (o_tick[c]),
      .o_slow_clk (o_slow_clk[c])
    );
  end

endmodule
